magic_packet_checker: RTL and testbench
=======================================

# magic_packet_checker

Output-side companion to the magic-packet tracker: observes both ends of a FIFO, captures one nondeterministically chosen "magic" packet at the write port, counts the entries ahead of it, and checks the word at the read port when that packet exits. It raises a registered check pulse with a pass/fail result and a sticky failure flag. It sits beside the FIFO under test in the formal and simulation harness and only observes the FIFO; it drives nothing back into it.

## Interface
- DEPTH, 8, FIFO capacity in entries
- WIDTH, 8, FIFO data width
- CNTWID, $clog2(DEPTH)+1, counter width; holds 0..DEPTH
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- push  in  1  FIFO write request
- pop  in  1  FIFO read request
- full  in  1  FIFO full
- empty  in  1  FIFO empty
- data_in  in  WIDTH  FIFO write data
- data_out  in  WIDTH  FIFO read data, head of queue
- en_capture  in  1  free/nondeterministic choice; selects the current accepted push as magic
- state  out  2  0=WAIT, 1=TRACK, 2=DONE (3 unused)
- cnt  out  CNTWID  WAIT: FIFO occupancy; TRACK: entries ahead of magic packet
- magic_data  out  WIDTH  captured magic word
- check_valid  out  1  one-cycle pulse; magic packet was popped in the previous cycle
- check_ok  out  1  valid with check_valid; popped word equalled magic_data
- fail  out  1  sticky; a mismatch or a lost packet was detected

## Operation
- Define push_acc = push & ~full and pop_acc = pop & ~empty. All bookkeeping uses these accepted events only.
- Reset (rst_n=0, async) sets:
  - state = WAIT
  - cnt, magic_data, check_valid, check_ok, fail = 0
- WAIT:
  - cnt <= cnt + push_acc - pop_acc.
  - cnt increments only while cnt != DEPTH and decrements only while cnt != 0; no wrap.
  - If push_acc & en_capture:
    - magic_data <= data_in
    - state <= TRACK
    - cnt <= cnt - pop_acc (floored at 0). The magic entry itself is not counted.
  - en_capture without push_acc is ignored.
- TRACK:
  - Pushes are ignored and en_capture is ignored.
  - pop_acc with cnt != 0: cnt <= cnt - 1.
  - pop_acc with cnt == 0 (magic packet exits):
    - state <= DONE
    - check_valid <= 1
    - check_ok <= (data_out == magic_data)
    - fail <= fail | (data_out != magic_data)
  - empty asserted in TRACK is a lost-packet violation: fail <= 1. State and cnt are unchanged by the violation.
- DONE:
  - All inputs are ignored and cnt holds.
  - The only exit is reset.
- Only one packet is checked per reset interval.

## Timing
- Everything is registered. Outputs change only on the rising clk edge or on async reset assertion.
- check_valid/check_ok:
  - Asserted the cycle after the exit pop, for exactly one cycle.
  - Both return to 0 the following cycle; check_ok is 0 whenever check_valid is 0.
- fail:
  - Sets the cycle after the offending event.
  - Never clears except on reset.
- Capture edge: state reads TRACK the cycle after the capturing push. A pop in that same cycle counts against entries ahead of the magic packet, never against the magic packet itself.
- Reset asserted mid-TRACK: the block returns to WAIT immediately and any pending check is discarded. After release, cnt restarts at 0 regardless of FIFO contents; the harness resets the FIFO together with this block.

## Test plan
- Capture on first push into an empty FIFO:
  - Stimulus: push 0xA5 with en_capture=1; idle 2 cycles; pop with data_out=0xA5.
  - Required: state TRACK, cnt=0; one cycle after the pop, check_valid=1, check_ok=1, state=DONE, fail=0.
- Three entries ahead:
  - Stimulus: push 0x11, 0x22, 0x33; then push 0x44 with en_capture=1.
  - Required: cnt=3 in TRACK.
  - Stimulus: pop 0x11, 0x22, 0x33.
  - Required: cnt goes 2, 1, 0; no check_valid.
  - Stimulus: pop with data_out=0x44.
  - Required: check_ok=1.
- Mismatch:
  - Stimulus: capture 0x5A; pop with data_out=0x5B.
  - Required: next cycle check_valid=1, check_ok=0, fail=1; fail stays 1 for at least 10 further cycles.
- Simultaneous capture and pop:
  - Stimulus: occupancy 2; capturing push and pop_acc in the same cycle.
  - Required: cnt=1 in TRACK; the magic word exits on the second subsequent pop.
- Full and lost-packet:
  - Stimulus: push with full=1 and en_capture=1.
  - Required: state stays WAIT, cnt unchanged.
  - Stimulus: in TRACK, drive empty=1 for one cycle.
  - Required: fail=1 the next cycle, state still TRACK.
- Async reset mid-TRACK:
  - Stimulus: drop rst_n between clock edges.
  - Required: state=0 and cnt=0 immediately.
  - Stimulus: post-release pops with nothing captured.
  - Required: no check_valid.

Source files
------------

// File: rtl/magic_packet_checker_if.sv
// -----------------------------------------------------------------------------
// magic_packet_checker_if
//
// Purpose: bundles the FIFO observation signals and the checker result signals
//          for magic_packet_checker. The checker only watches the FIFO, so every
//          FIFO-side signal is an input on the slave (checker) modport.
//
// Signal summary:
//   push, pop        FIFO write / read requests
//   full, empty      FIFO status flags
//   data_in          FIFO write data
//   data_out         FIFO read data (head of queue)
//   en_capture       free choice: mark the current accepted push as magic
//   state            0=WAIT, 1=TRACK, 2=DONE
//   cnt              WAIT: occupancy; TRACK: entries ahead of the magic packet
//   magic_data       captured magic word
//   check_valid      one-cycle pulse, magic packet popped in the previous cycle
//   check_ok         popped word matched magic_data (valid with check_valid)
//   fail             sticky failure flag
//
// Modports:
//   master  harness side, drives the FIFO observation signals
//   slave   checker side, drives the result signals
// -----------------------------------------------------------------------------
interface magic_packet_checker_if #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1
);
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              en_capture;
    logic [1:0]        state;
    logic [CNTWID-1:0] cnt;
    logic [WIDTH-1:0]  magic_data;
    logic              check_valid;
    logic              check_ok;
    logic              fail;

    modport master (
        output push, pop, full, empty, data_in, data_out, en_capture,
        input  state, cnt, magic_data, check_valid, check_ok, fail
    );

    modport slave (
        input  push, pop, full, empty, data_in, data_out, en_capture,
        output state, cnt, magic_data, check_valid, check_ok, fail
    );
endinterface

// File: rtl/magic_packet_checker.sv
// -----------------------------------------------------------------------------
// magic_packet_checker
//
// Purpose: watches both ends of a FIFO, captures one freely chosen "magic"
//          packet at the write port, counts the entries queued ahead of it and
//          checks the word seen at the read port when that packet leaves.
//          Produces a one-cycle check pulse with a pass/fail result and a
//          sticky failure flag. Drives nothing back into the FIFO.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   chk    magic_packet_checker_if.slave (FIFO observation in, results out)
//
// Parameters:
//   DEPTH   FIFO capacity in entries
//   WIDTH   FIFO data width
//   CNTWID  counter width, holds 0..DEPTH
// -----------------------------------------------------------------------------
module magic_packet_checker #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    magic_packet_checker_if.slave chk
);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [CNTWID-1:0] CNT_ONE   = CNTWID'(1);
    localparam logic [CNTWID-1:0] CNT_DEPTH = CNTWID'(DEPTH);

    state_t            r_state;
    logic [CNTWID-1:0] r_cnt;
    logic [WIDTH-1:0]  r_magic_data;
    logic              r_check_valid;
    logic              r_check_ok;
    logic              r_fail;

    logic              w_push_acc;
    logic              w_pop_acc;
    logic              w_cnt_zero;
    logic              w_cnt_full;
    logic              w_inc;
    logic              w_dec;
    logic [CNTWID-1:0] w_cnt_occ_next;
    logic [CNTWID-1:0] w_cnt_pop_next;
    logic              w_data_match;

    // Only accepted FIFO events move the bookkeeping.
    assign w_push_acc = chk.push & ~chk.full;
    assign w_pop_acc  = chk.pop  & ~chk.empty;

    assign w_cnt_zero = (r_cnt == '0);
    assign w_cnt_full = (r_cnt == CNT_DEPTH);

    // Saturating occupancy update used while waiting for a capture.
    assign w_inc          = w_push_acc & ~w_cnt_full;
    assign w_dec          = w_pop_acc  & ~w_cnt_zero;
    assign w_cnt_occ_next = r_cnt + (w_inc ? CNT_ONE : '0) - (w_dec ? CNT_ONE : '0);

    // On the capturing push the magic entry itself is not counted, so only a
    // simultaneous pop can change the count (floored at zero).
    assign w_cnt_pop_next = w_dec ? (r_cnt - CNT_ONE) : r_cnt;

    assign w_data_match = (chk.data_out == r_magic_data);

    // Single registered FSM; every output below is a flop.
    // NOTE: sequential state uses non-blocking assignments so all flops update
    //       from the same pre-edge values and simulation matches hardware.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_WAIT;
            r_cnt         <= '0;
            r_magic_data  <= '0;
            r_check_valid <= 1'b0;
            r_check_ok    <= 1'b0;
            r_fail        <= 1'b0;
        end else begin
            // The check pulse lasts exactly one cycle; check_ok is only
            // meaningful alongside it and is cleared with it.
            r_check_valid <= 1'b0;
            r_check_ok    <= 1'b0;

            case (r_state)
                ST_WAIT: begin
                    if (w_push_acc && chk.en_capture) begin
                        r_magic_data <= chk.data_in;
                        r_state      <= ST_TRACK;
                        r_cnt        <= w_cnt_pop_next;
                    end else begin
                        r_cnt <= w_cnt_occ_next;
                    end
                end

                ST_TRACK: begin
                    // An empty FIFO while the magic packet is still owed means
                    // the packet was lost. Flag it and keep tracking.
                    if (chk.empty) begin
                        r_fail <= 1'b1;
                    end

                    if (w_pop_acc) begin
                        if (w_cnt_zero) begin
                            // Nothing ahead: this pop is the magic packet.
                            r_state       <= ST_DONE;
                            r_check_valid <= 1'b1;
                            r_check_ok    <= w_data_match;
                            r_fail        <= r_fail | ~w_data_match;
                        end else begin
                            r_cnt <= r_cnt - CNT_ONE;
                        end
                    end
                end

                ST_DONE: begin
                    // One packet per reset interval; hold until reset.
                end

                default: begin
                    r_state <= ST_WAIT;
                end
            endcase
        end
    end

    assign chk.state       = r_state;
    assign chk.cnt         = r_cnt;
    assign chk.magic_data  = r_magic_data;
    assign chk.check_valid = r_check_valid;
    assign chk.check_ok    = r_check_ok;
    assign chk.fail        = r_fail;

endmodule

// File: tb/tb_magic_packet_checker.sv
// -----------------------------------------------------------------------------
// tb_magic_packet_checker
//
// Directed bench for magic_packet_checker. A small FIFO model supplies full,
// empty and data_out; expected check results are queued when the exit pop is
// driven and compared when the checker pulses check_valid.
// -----------------------------------------------------------------------------
module tb_magic_packet_checker;

    localparam int DEPTH  = 8;
    localparam int WIDTH  = 8;
    localparam int CNTWID = $clog2(DEPTH) + 1;

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic clk;
    logic rst_n;

    magic_packet_checker_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTWID(CNTWID)) bus ();

    magic_packet_checker #(.DEPTH(DEPTH), .WIDTH(WIDTH), .CNTWID(CNTWID)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .chk   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [WIDTH-1:0] fifo_q[$];
    logic             sb_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive FIFO status from the model, with optional forced flags/corruption.
    task automatic refresh(input bit f_full, input bit f_empty, input bit corrupt);
        bus.full     = f_full  || (fifo_q.size() == DEPTH);
        bus.empty    = f_empty || (fifo_q.size() == 0);
        bus.data_out = (fifo_q.size() > 0) ? (fifo_q[0] ^ {{(WIDTH-1){1'b0}}, corrupt}) : '0;
    endtask

    // Advance one clock and sample #1 after the edge; consume the scoreboard
    // whenever the checker reports.
    task automatic tick();
        logic exp_ok;
        @(posedge clk);
        #1;
        if (bus.check_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_check_valid", bus.check_valid, 0);
            end else begin
                exp_ok = sb_q.pop_front();
                check("check_ok", bus.check_ok, exp_ok);
            end
        end
    endtask

    task automatic cycle(input bit p, input bit r,
                         input logic [WIDTH-1:0] d = '0, input bit cap = 1'b0,
                         input bit f_full = 1'b0, input bit f_empty = 1'b0,
                         input bit corrupt = 1'b0);
        bit acc_push;
        bit acc_pop;
        bus.push       = p;
        bus.pop        = r;
        bus.data_in    = d;
        bus.en_capture = cap;
        refresh(f_full, f_empty, corrupt);
        acc_push = p && !bus.full;
        acc_pop  = r && !bus.empty;
        tick();
        if (acc_pop)  void'(fifo_q.pop_front());
        if (acc_push) fifo_q.push_back(d);
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.data_in    = '0;
        bus.en_capture = 1'b0;
        refresh(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        check("sb_drained_before_reset", sb_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b0;
        fifo_q.delete();
        refresh(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus.push       = 1'b0;
        bus.pop        = 1'b0;
        bus.data_in    = '0;
        bus.en_capture = 1'b0;
        refresh(1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state
        check("rst_state", bus.state, S_WAIT);
        check("rst_cnt", bus.cnt, 0);
        check("rst_magic", bus.magic_data, 0);
        check("rst_check_valid", bus.check_valid, 0);
        check("rst_check_ok", bus.check_ok, 0);
        check("rst_fail", bus.fail, 0);

        // Capture on first push into an empty FIFO
        cycle(1, 0, 8'hA5, 1);
        check("t1_state", bus.state, S_TRACK);
        check("t1_cnt", bus.cnt, 0);
        check("t1_magic", bus.magic_data, 8'hA5);
        cycle(0, 0);
        cycle(0, 0);
        check("t1_state_idle", bus.state, S_TRACK);
        sb_q.push_back(1'b1);
        cycle(0, 1);
        check("t1_check_valid", bus.check_valid, 1);
        check("t1_done", bus.state, S_DONE);
        check("t1_fail", bus.fail, 0);
        cycle(0, 0);
        check("t1_cv_drop", bus.check_valid, 0);
        check("t1_ok_drop", bus.check_ok, 0);

        // Three entries ahead of the magic packet
        do_reset();
        cycle(1, 0, 8'h11);
        cycle(1, 0, 8'h22);
        cycle(1, 0, 8'h33);
        check("t2_occ", bus.cnt, 3);
        check("t2_wait", bus.state, S_WAIT);
        cycle(1, 0, 8'h44, 1);
        check("t2_track", bus.state, S_TRACK);
        check("t2_cnt3", bus.cnt, 3);
        for (int i = 2; i >= 0; i--) begin
            cycle(0, 1);
            check("t2_cnt_dec", bus.cnt, i);
            check("t2_no_check", bus.check_valid, 0);
        end
        sb_q.push_back(1'b1);
        cycle(0, 1);
        check("t2_done", bus.state, S_DONE);

        // Mismatch
        do_reset();
        cycle(1, 0, 8'h5A, 1);
        sb_q.push_back(1'b0);
        cycle(0, 1, '0, 0, 0, 0, 1);
        check("t3_check_valid", bus.check_valid, 1);
        check("t3_fail", bus.fail, 1);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0);
            check("t3_fail_sticky", bus.fail, 1);
        end

        // Simultaneous capture and pop
        do_reset();
        cycle(1, 0, 8'h01);
        cycle(1, 0, 8'h02);
        check("t4_occ", bus.cnt, 2);
        cycle(1, 1, 8'h03, 1);
        check("t4_track", bus.state, S_TRACK);
        check("t4_cnt", bus.cnt, 1);
        cycle(0, 1);
        check("t4_first_pop_no_check", bus.check_valid, 0);
        check("t4_cnt0", bus.cnt, 0);
        sb_q.push_back(1'b1);
        cycle(0, 1);
        check("t4_second_pop_check", bus.check_valid, 1);

        // Full push is ignored; lost packet sets fail
        do_reset();
        cycle(1, 0, 8'h77);
        cycle(1, 0, 8'h88, 1, 1);
        check("t5_full_state", bus.state, S_WAIT);
        check("t5_full_cnt", bus.cnt, 1);
        cycle(1, 0, 8'h99, 1);
        check("t5_track", bus.state, S_TRACK);
        check("t5_fail_clear", bus.fail, 0);
        cycle(0, 0, '0, 0, 0, 1);
        check("t5_lost_fail", bus.fail, 1);
        check("t5_lost_state", bus.state, S_TRACK);
        check("t5_lost_cnt", bus.cnt, 1);

        // Asynchronous reset mid-TRACK
        do_reset();
        cycle(1, 0, 8'h10);
        cycle(1, 0, 8'h20, 1);
        check("t6_track", bus.state, S_TRACK);
        check("t6_cnt", bus.cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_state", bus.state, S_WAIT);
        check("t6_async_cnt", bus.cnt, 0);
        check("sb_drained_before_async", sb_q.size(), 0);
        fifo_q.delete();
        refresh(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 0, 8'h30);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1);
            check("t6_no_check", bus.check_valid, 0);
            check("t6_still_wait", bus.state, S_WAIT);
        end
        check("t6_cnt_end", bus.cnt, 0);

        check("sb_drained_end", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
